// File: rtl/mrdy_wait_ctrl.sv
// MRDYn wait-state scheduler: stretches the main CPU E/Q clocks for slow I/O and BTRDYn holds.
// Optional forced-release timeout is built when MRDY_WAIT_TIMEOUT_EN is defined.
module mrdy_wait_ctrl #(
  parameter int unsigned IO_WAIT     = 2,
  parameter int unsigned MIN_BT_WAIT = 1,
  parameter int unsigned TIMEOUT     = 1023,
  parameter int unsigned TW          = 10
) (
  input  logic       CLKSYS,
  input  logic       RESETBn,
  input  logic       MCPU_CE,
  input  logic       EB,
  input  logic       FM7MODE,
  input  logic       IOSn,
  input  logic       BTRDYn,
  input  logic       TMCLRn,
  output logic       MRDYn,
  output logic       BUSY,
  output logic       TMOUT,
  output logic [7:0] WCNT
);

  typedef enum logic [1:0] {StIdle, StHold, StCount, StRelease} state_e;

  localparam logic [TW-1:0] IoWaitTk  = TW'(IO_WAIT);
  localparam logic [TW-1:0] MinBtTk   = TW'(MIN_BT_WAIT);
  localparam logic [TW-1:0] TimeoutTk = TW'(TIMEOUT);

  state_e        state_q, state_d;
  logic          eb_q;
  logic [TW-1:0] tk_q, tk_d, tk_inc;
  logic [TW-1:0] dcnt_q, dcnt_d;
  logic          mrdy_n_q, busy_q;
  logic [7:0]    wcnt_q, wcnt_sat;
  logic [31:0]   tk_wide;
  logic          start, stretching, timeout_hit;

  assign start      = EB && !eb_q && (state_q == StIdle);
  assign stretching = (state_q == StHold) || (state_q == StCount);
  // Saturate so an unbounded hold cannot wrap the reported stretch length.
  assign tk_inc     = (&tk_q) ? tk_q : tk_q + TW'(1);

`ifdef MRDY_WAIT_TIMEOUT_EN
  logic tmout_q;

  assign timeout_hit = stretching && MCPU_CE && (tk_inc == TimeoutTk);

  always_ff @(posedge CLKSYS or negedge RESETBn) begin
    if (!RESETBn) begin
      tmout_q <= 1'b0;
    end else if (timeout_hit) begin
      tmout_q <= 1'b1;
    end else if (!TMCLRn) begin
      tmout_q <= 1'b0;
    end
  end

  assign TMOUT = tmout_q;
`else
  logic unused_cfg;

  assign timeout_hit = 1'b0;
  assign TMOUT       = 1'b0;
  assign unused_cfg  = ^{TMCLRn, TimeoutTk};
`endif

  always_comb begin
    state_d = state_q;
    tk_d    = tk_q;
    dcnt_d  = dcnt_q;
    unique case (state_q)
      StIdle: begin
        if (start && FM7MODE) begin
          if (!BTRDYn) begin
            state_d = StHold;
            tk_d    = '0;
          end else if (!IOSn && (IO_WAIT > 0)) begin
            state_d = StCount;
            tk_d    = '0;
            dcnt_d  = IoWaitTk;
          end
        end
      end
      StHold: begin
        if (MCPU_CE) tk_d = tk_inc;
        if (!FM7MODE || timeout_hit || (BTRDYn && (tk_q >= MinBtTk))) state_d = StRelease;
      end
      StCount: begin
        if (MCPU_CE) begin
          tk_d   = tk_inc;
          dcnt_d = dcnt_q - TW'(1);
          if (dcnt_q == TW'(1)) state_d = StRelease;
        end
        if (!FM7MODE || timeout_hit) state_d = StRelease;
      end
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  assign tk_wide  = 32'(tk_q);
  assign wcnt_sat = (tk_wide > 32'd255) ? 8'hff : tk_wide[7:0];

  always_ff @(posedge CLKSYS or negedge RESETBn) begin
    if (!RESETBn) begin
      state_q  <= StIdle;
      eb_q     <= 1'b0;
      tk_q     <= '0;
      dcnt_q   <= '0;
      mrdy_n_q <= 1'b1;
      busy_q   <= 1'b0;
      wcnt_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      eb_q     <= EB;
      tk_q     <= tk_d;
      dcnt_q   <= dcnt_d;
      // Registered from the next state so MRDYn moves on the deciding edge.
      mrdy_n_q <= !((state_d == StHold) || (state_d == StCount));
      busy_q   <= (state_d != StIdle);
      if (state_q == StRelease) wcnt_q <= wcnt_sat;
    end
  end

  assign MRDYn = mrdy_n_q;
  assign BUSY  = busy_q;
  assign WCNT  = wcnt_q;

endmodule

// File: tb/tb_mrdy_wait_ctrl.sv
// Bench for mrdy_wait_ctrl: WCNT scoreboard on the main instance plus MRDYn/BUSY/TMOUT spot checks.
module tb_mrdy_wait_ctrl;

  logic CLKSYS, RESETBn, MCPU_CE, EB, FM7MODE, IOSn, BTRDYn, TMCLRn;
  logic       mrdy_n, busy, tmout;
  logic [7:0] wcnt;
  logic       mrdy_n6, busy6, tmout6;
  logic [7:0] wcnt6;
  logic       mrdy_n1, busy1, tmout1;
  logic [7:0] wcnt1;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned wcnt_q[$];
  logic        busy_prev = 1'b0;

  mrdy_wait_ctrl #(.IO_WAIT(2), .MIN_BT_WAIT(1), .TIMEOUT(8), .TW(10)) dut (
    .CLKSYS(CLKSYS), .RESETBn(RESETBn), .MCPU_CE(MCPU_CE), .EB(EB), .FM7MODE(FM7MODE),
    .IOSn(IOSn), .BTRDYn(BTRDYn), .TMCLRn(TMCLRn),
    .MRDYn(mrdy_n), .BUSY(busy), .TMOUT(tmout), .WCNT(wcnt)
  );

  mrdy_wait_ctrl #(.IO_WAIT(6), .MIN_BT_WAIT(1), .TIMEOUT(8), .TW(10)) dut6 (
    .CLKSYS(CLKSYS), .RESETBn(RESETBn), .MCPU_CE(MCPU_CE), .EB(EB), .FM7MODE(FM7MODE),
    .IOSn(IOSn), .BTRDYn(BTRDYn), .TMCLRn(TMCLRn),
    .MRDYn(mrdy_n6), .BUSY(busy6), .TMOUT(tmout6), .WCNT(wcnt6)
  );

  mrdy_wait_ctrl #(.IO_WAIT(1), .MIN_BT_WAIT(1), .TIMEOUT(8), .TW(10)) dut1 (
    .CLKSYS(CLKSYS), .RESETBn(RESETBn), .MCPU_CE(MCPU_CE), .EB(EB), .FM7MODE(FM7MODE),
    .IOSn(IOSn), .BTRDYn(BTRDYn), .TMCLRn(TMCLRn),
    .MRDYn(mrdy_n1), .BUSY(busy1), .TMOUT(tmout1), .WCNT(wcnt1)
  );

  initial CLKSYS = 1'b0;
  always #5 CLKSYS = ~CLKSYS;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One CLKSYS cycle; ce marks it as a tick. Returns 1 time unit after the edge.
  task automatic clk1(input logic ce);
    MCPU_CE = ce;
    @(posedge CLKSYS);
    #1;
    MCPU_CE = 1'b0;
  endtask

  // Completed accesses on the main instance are scored when BUSY falls.
  always @(negedge CLKSYS) begin
    if (RESETBn && busy_prev && !busy) begin
      if (wcnt_q.size() == 0) check_eq("sb_underflow", 1, 0);
      else check_eq("sb_wcnt", wcnt, wcnt_q.pop_front());
    end
    busy_prev = busy;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    RESETBn = 1'b0; MCPU_CE = 1'b0; EB = 1'b0; FM7MODE = 1'b1;
    IOSn = 1'b1; BTRDYn = 1'b1; TMCLRn = 1'b1;
    repeat (2) @(posedge CLKSYS);
    #1;
    check_eq("rst_mrdy", mrdy_n, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_tmout", tmout, 0);
    check_eq("rst_wcnt", wcnt, 0);
    RESETBn = 1'b1;
    clk1(0); clk1(0);

    // I/O stretch, reset asserted at tick 3 of the 6-tick instance
    IOSn = 1'b0;
    wcnt_q.push_back(2);
    EB = 1'b1; clk1(0);
    check_eq("io_start_mrdy", mrdy_n, 0);
    check_eq("io_start_busy", busy, 1);
    EB = 1'b0; IOSn = 1'b1;
    clk1(0); clk1(1);
    check_eq("io_tick1_mrdy", mrdy_n, 0);
    clk1(0); clk1(1);
    check_eq("io_tick2_mrdy", mrdy_n, 1);
    check_eq("io_release_busy", busy, 1);
    clk1(0); clk1(1);
    check_eq("w6_tick3_mrdy", mrdy_n6, 0);
    RESETBn = 1'b0;
    #1;
    check_eq("w6_async_mrdy", mrdy_n6, 1);
    check_eq("w6_async_wcnt", wcnt6, 0);
    clk1(0);
    RESETBn = 1'b1;
    clk1(0);
    IOSn = 1'b0;
    wcnt_q.push_back(2);
    EB = 1'b1; clk1(0);
    check_eq("w6_restart_mrdy", mrdy_n6, 0);
    EB = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      clk1(0); clk1(1);
      if (i == 5) check_eq("w6_tick5_mrdy", mrdy_n6, 0);
      if (i == 6) check_eq("w6_tick6_mrdy", mrdy_n6, 1);
    end
    clk1(0);
    check_eq("w6_wcnt", wcnt6, 6);

    // Non-I/O access: no stretch
    IOSn = 1'b1; BTRDYn = 1'b1;
    EB = 1'b1; clk1(0);
    check_eq("mem_mrdy", mrdy_n, 1);
    check_eq("mem_busy", busy, 0);
    EB = 1'b0; clk1(1); clk1(0);

    // BTRDYn hold for 5 ticks, with IOSn also low
    IOSn = 1'b0; BTRDYn = 1'b0;
    wcnt_q.push_back(5);
    EB = 1'b1; clk1(0);
    check_eq("hold_start_mrdy", mrdy_n, 0);
    EB = 1'b0;
    repeat (5) begin clk1(0); clk1(1); end
    check_eq("hold_t5_mrdy", mrdy_n, 0);
    BTRDYn = 1'b1; clk1(0);
    check_eq("hold_release_mrdy", mrdy_n, 1);
    clk1(0);

    // BTRDYn released before any tick: held until the first tick
    BTRDYn = 1'b0;
    wcnt_q.push_back(1);
    EB = 1'b1; clk1(0);
    EB = 1'b0; BTRDYn = 1'b1;
    clk1(0);
    check_eq("minbt_c1_mrdy", mrdy_n, 0);
    clk1(0);
    check_eq("minbt_c2_mrdy", mrdy_n, 0);
    clk1(1);
    check_eq("minbt_tick_mrdy", mrdy_n, 0);
    clk1(0);
    check_eq("minbt_release_mrdy", mrdy_n, 1);
    clk1(0);

    // FM-8 mode: never stretches
    FM7MODE = 1'b0;
    for (int p = 0; p < 4; p++) begin
      IOSn = p[1]; BTRDYn = p[0];
      EB = 1'b1; clk1(0);
      check_eq("fm8_mrdy", mrdy_n, 1);
      check_eq("fm8_busy", busy, 0);
      EB = 1'b0; clk1(1);
      check_eq("fm8_tick_mrdy", mrdy_n, 1);
      clk1(0);
    end

    // Abort by dropping FM7MODE mid-hold
    FM7MODE = 1'b1; IOSn = 1'b1; BTRDYn = 1'b0;
    wcnt_q.push_back(2);
    EB = 1'b1; clk1(0);
    EB = 1'b0; clk1(1); clk1(1);
    check_eq("abort_pre_mrdy", mrdy_n, 0);
    FM7MODE = 1'b0; clk1(0);
    check_eq("abort_mrdy", mrdy_n, 1);
    check_eq("abort_release_busy", busy, 1);
    clk1(0);
    check_eq("abort_idle_busy", busy, 0);
    FM7MODE = 1'b1; BTRDYn = 1'b1;
    clk1(0);

    // Tick coincident with the start cycle is not counted
    IOSn = 1'b0;
    wcnt_q.push_back(2);
    EB = 1'b1; clk1(1);
    check_eq("coin_start_mrdy", mrdy_n1, 0);
    EB = 1'b0; clk1(0);
    check_eq("coin_hold_mrdy", mrdy_n1, 0);
    clk1(1);
    check_eq("coin_tick_mrdy", mrdy_n1, 1);
    clk1(0);
    check_eq("coin_wcnt", wcnt1, 1);
    clk1(1); clk1(0);

    // EB edge landing in RELEASE must not retrigger
    wcnt_q.push_back(2);
    EB = 1'b1; clk1(0);
    EB = 1'b0; clk1(0); clk1(1); clk1(0); clk1(1);
    EB = 1'b1; clk1(0);
    check_eq("retrig_mrdy", mrdy_n, 1);
    clk1(0);
    check_eq("retrig_busy", busy, 0);
    check_eq("retrig_mrdy2", mrdy_n, 1);
    EB = 1'b0; clk1(0);

`ifdef MRDY_WAIT_TIMEOUT_EN
    // Stuck BTRDYn: forced release on the 8th tick
    IOSn = 1'b1; BTRDYn = 1'b0;
    wcnt_q.push_back(8);
    EB = 1'b1; clk1(0);
    EB = 1'b0;
    repeat (7) begin clk1(0); clk1(1); end
    check_eq("to_t7_mrdy", mrdy_n, 0);
    check_eq("to_t7_tmout", tmout, 0);
    clk1(0); clk1(1);
    check_eq("to_t8_mrdy", mrdy_n, 1);
    check_eq("to_t8_tmout", tmout, 1);
    clk1(0);
    TMCLRn = 1'b0; clk1(0);
    check_eq("to_clr_tmout", tmout, 0);
    TMCLRn = 1'b1;
    wcnt_q.push_back(8);
    EB = 1'b1; clk1(0);
    EB = 1'b0;
    repeat (7) begin clk1(0); clk1(1); end
    clk1(0);
    TMCLRn = 1'b0; clk1(1);
    check_eq("to_setwins_tmout", tmout, 1);
    TMCLRn = 1'b1; clk1(0);
    BTRDYn = 1'b1;
`endif

    clk1(0); clk1(0); clk1(0);
    check_eq("sb_drain", wcnt_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
